// File: rtl/mcbsp_frame_engine_if.sv
// Bundles the McBSP pins, the per-word AXIS TX inputs and the RX/status
// outputs of the frame engine into one port. The engine side uses the slave
// modport; whatever drives the pins and words uses the master modport.
interface mcbsp_frame_engine_if #(
    parameter int WORDS_PER_FRAME = 8,
    parameter int BITS_PER_WORD   = 32,
    parameter int CNT_WIDTH       = 16
);
    localparam int N = WORDS_PER_FRAME * BITS_PER_WORD;

    logic                       mcbsp_clk;
    logic                       mcbsp_frame_start;
    logic                       mcbsp_data_rx;
    logic                       mcbsp_data_tx;
    logic                       mcbsp_data_frm;
    logic                       trigger;
    logic [N-1:0]               S_AXIS_tdata;
    logic [WORDS_PER_FRAME-1:0] S_AXIS_tvalid;
    logic [N-1:0]               rx_frame;
    logic                       rx_valid;
    logic [CNT_WIDTH-1:0]       frame_count;
    logic [CNT_WIDTH-1:0]       sync_err_count;

    modport master (
        output mcbsp_clk, mcbsp_frame_start, mcbsp_data_rx,
        output S_AXIS_tdata, S_AXIS_tvalid,
        input  mcbsp_data_tx, mcbsp_data_frm, trigger,
        input  rx_frame, rx_valid, frame_count, sync_err_count
    );

    modport slave (
        input  mcbsp_clk, mcbsp_frame_start, mcbsp_data_rx,
        input  S_AXIS_tdata, S_AXIS_tvalid,
        output mcbsp_data_tx, mcbsp_data_frm, trigger,
        output rx_frame, rx_valid, frame_count, sync_err_count
    );
endinterface

// File: rtl/mcbsp_frame_engine.sv
// McBSP slave frame engine. The external bit clock, frame sync and RX data are
// oversampled on a_clk; rising edges of the bit clock launch TX bits, falling
// edges sample RX bits. A whole WORDS_PER_FRAME x BITS_PER_WORD frame is
// shifted per frame sync, with frame and sync-error counters.
module mcbsp_frame_engine #(
    parameter int WORDS_PER_FRAME = 8,
    parameter int BITS_PER_WORD   = 32,
    parameter bit MSB_FIRST       = 1'b1,
    parameter int SYNC_STAGES     = 2,
    parameter int CNT_WIDTH       = 16
) (
    input  logic a_clk,
    input  logic a_resetn,
    mcbsp_frame_engine_if.slave bus
);
    localparam int N  = WORDS_PER_FRAME * BITS_PER_WORD;
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] clk_sync, fs_sync, rx_sync;
    logic                   clk_prev;
    logic                   clk_s, fs_s, rx_s;
    logic                   rise, fall;

    logic [N-1:0]  hold, shadow, rx_shift, rx_merged, rx_frame;
    logic [CW-1:0] cnt, idx;
    logic          start_frame, sync_err;
    logic          tx, trigger, rx_valid;
    logic [CNT_WIDTH-1:0] frame_count, sync_err_count;

    assign clk_s = clk_sync[SYNC_STAGES-1];
    assign fs_s  = fs_sync[SYNC_STAGES-1];
    assign rx_s  = rx_sync[SYNC_STAGES-1];
    assign rise  = clk_s & ~clk_prev;
    assign fall  = ~clk_s & clk_prev;
    assign idx   = MSB_FIRST ? cnt : (LAST - cnt);

    // Synchronise the three McBSP inputs; one extra clock flop finds edges
    always_ff @(posedge a_clk) begin
        if (!a_resetn) begin
            clk_sync <= '0;
            fs_sync  <= '0;
            rx_sync  <= '0;
            clk_prev <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], bus.mcbsp_clk};
            fs_sync  <= {fs_sync[SYNC_STAGES-2:0], bus.mcbsp_frame_start};
            rx_sync  <= {rx_sync[SYNC_STAGES-2:0], bus.mcbsp_data_rx};
            clk_prev <= clk_s;
        end
    end

    // Holding register: each word refreshes only while its valid is high
    always_ff @(posedge a_clk) begin
        if (!a_resetn) begin
            hold <= '0;
        end else begin
            for (int w = 0; w < WORDS_PER_FRAME; w++) begin
                if (bus.S_AXIS_tvalid[w])
                    hold[w*BITS_PER_WORD +: BITS_PER_WORD] <= bus.S_AXIS_tdata[w*BITS_PER_WORD +: BITS_PER_WORD];
            end
        end
    end

    // Frame state register
    always_ff @(posedge a_clk) begin
        if (!a_resetn) state <= IDLE;
        else           state <= state_next;
    end

    // Next state; a frame sync seen mid-frame restarts the frame at once
    always_comb begin
        state_next  = state;
        start_frame = 1'b0;
        sync_err    = 1'b0;
        rx_merged   = rx_shift;
        rx_merged[idx] = rx_s;
        case (state)
            IDLE: begin
                if (fall && fs_s) begin
                    state_next  = SHIFT;
                    start_frame = 1'b1;
                end
            end
            SHIFT: begin
                if (fall) begin
                    if (fs_s) begin
                        sync_err    = 1'b1;
                        start_frame = 1'b1;
                    end else if (cnt == '0) begin
                        state_next = DONE;
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: shadow capture, bit counter, TX launch, RX capture, counters
    always_ff @(posedge a_clk) begin
        if (!a_resetn) begin
            shadow         <= '0;
            cnt            <= '0;
            tx             <= 1'b0;
            trigger        <= 1'b0;
            rx_shift       <= '0;
            rx_frame       <= '0;
            rx_valid       <= 1'b0;
            frame_count    <= '0;
            sync_err_count <= '0;
        end else begin
            trigger  <= start_frame;
            rx_valid <= 1'b0;
            if (start_frame) begin
                shadow <= hold;
                cnt    <= LAST;
            end else if (state == SHIFT && fall) begin
                rx_shift <= rx_merged;
                if (cnt == '0) begin
                    rx_frame <= rx_merged;
                    rx_valid <= 1'b1;
                end else begin
                    cnt <= cnt - CW'(1);
                end
            end
            if (state == SHIFT && rise)
                tx <= shadow[idx];
            if (sync_err && (sync_err_count != '1))
                sync_err_count <= sync_err_count + CNT_WIDTH'(1);
            if (state == DONE)
                frame_count <= frame_count + CNT_WIDTH'(1);
        end
    end

    assign bus.mcbsp_data_tx  = tx;
    assign bus.mcbsp_data_frm = (state == SHIFT);
    assign bus.trigger        = trigger;
    assign bus.rx_frame       = rx_frame;
    assign bus.rx_valid       = rx_valid;
    assign bus.frame_count    = frame_count;
    assign bus.sync_err_count = sync_err_count;
endmodule
